// File: rtl/tanh_sched_pkg.sv
// Shared types and defaults for the tanh issue scheduler and its result buffer.
// Holds the FSM state encoding, the tag format and the default pipeline/buffer sizing.
package tanh_sched_pkg;

    localparam int DATA_W         = 32;
    localparam int DEF_LATENCY    = 11;
    localparam int DEF_FIFO_DEPTH = 16;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sched_state_e;

    // Travels alongside the datapath so each result can be matched to its requester.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/tanh_sched_if.sv
// Request, datapath and result buses of the tanh scheduler.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface tanh_sched_if;
    import tanh_sched_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_x;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_x;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_x;
    logic [DATA_W-1:0] pipe_y;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_y;
    logic              res_id;

    modport slave (
        input  req0_valid, req0_x, req1_valid, req1_x, pipe_y, res_ready,
        output req0_ready, req1_ready, pipe_valid, pipe_x, res_valid, res_y, res_id
    );

    modport master (
        output req0_valid, req0_x, req1_valid, req1_x, pipe_y, res_ready,
        input  req0_ready, req1_ready, pipe_valid, pipe_x, res_valid, res_y, res_id
    );

endinterface

// File: rtl/tanh_res_fifo.sv
// First-word-fall-through result buffer: the head entry is visible whenever not empty.
// Pointers wrap modulo DEPTH; pop is ignored when empty, and push+pop leaves count unchanged.
module tanh_res_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             pop_eff;

    assign empty   = (count_q == '0);
    assign pop_eff = pop & ~empty;
    assign rdata   = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + AW'(1);
            if (pop_eff) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop_eff})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tanh_sched.sv
// Two-requester round-robin issue scheduler for a fixed-latency tanh datapath.
// Results are tagged through a shift register and re-ordered nowhere: they leave in issue order.
module tanh_sched
    import tanh_sched_pkg::*;
#(
    parameter int LATENCY    = DEF_LATENCY,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    tanh_sched_if.slave      bus,
    input  logic             flush,
    output logic             flush_done,
    output logic             busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

    sched_state_e      state_q;
    sched_state_e      state_d;
    logic              drain_done;
    logic              last_id_q;
    logic [CW-1:0]     inflight_q;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    tag_t              tag_q [LATENCY];
    logic              pipe_valid_q;
    logic              pipe_id_q;
    logic [DATA_W-1:0] pipe_x_q;

    logic              credit_ok;
    logic              grant0;
    logic              grant1;
    logic              can_accept;
    logic              ready0;
    logic              ready1;
    logic              accept;
    logic              acc_id;
    logic [DATA_W-1:0] acc_x;
    logic              tag_exit;

    // Everything accepted but not yet popped counts against the buffer, so a push never finds it full.
    assign credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight_q}) < SW'(FIFO_DEPTH);
    assign grant0     = bus.req0_valid & (~bus.req1_valid | last_id_q);
    assign grant1     = bus.req1_valid & (~bus.req0_valid | ~last_id_q);
    assign can_accept = (state_q == RUN) & credit_ok & ~reset;
    assign ready0     = can_accept & grant0;
    assign ready1     = can_accept & grant1;
    assign accept     = (ready0 & bus.req0_valid) | (ready1 & bus.req1_valid);
    assign acc_id     = ready1 & bus.req1_valid;
    assign acc_x      = acc_id ? bus.req1_x : bus.req0_x;
    assign tag_exit   = tag_q[LATENCY-1].valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid_q <= 1'b0;
            pipe_id_q    <= 1'b0;
            pipe_x_q     <= '0;
            last_id_q    <= 1'b1;
        end else begin
            pipe_valid_q <= accept;
            if (accept) begin
                pipe_id_q <= acc_id;
                pipe_x_q  <= acc_x;
                last_id_q <= acc_id;
            end
        end
    end

    // Tag stage 0 follows the issue register, so the last stage lines up with pipe_y.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: pipe_valid_q, id: pipe_id_q};
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= '0;
        end else begin
            case ({accept, tag_exit})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    tanh_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_res_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tag_exit),
        .wdata ({tag_q[LATENCY-1].id, bus.pipe_y}),
        .pop   (bus.res_ready),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        case (state_q)
            RUN:   if (flush) state_d = DRAIN;
            DRAIN: begin
                if (inflight_q == '0 && fifo_empty) begin
                    drain_done = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs are forced low for the whole reset cycle, not just after the first edge.
    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.pipe_valid = pipe_valid_q & ~reset;
    assign bus.pipe_x     = reset ? '0 : pipe_x_q;
    assign bus.res_valid  = ~fifo_empty & ~reset;
    assign bus.res_y      = reset ? '0 : fifo_head[DATA_W-1:0];
    assign bus.res_id     = fifo_head[DATA_W] & ~reset;
    assign flush_done     = drain_done & ~reset;
    assign busy           = ~reset & ((inflight_q != '0) | ~fifo_empty);

endmodule
